// File: rtl/network_source.sv
// Rebuilds a one-hot-per-input fire vector from a count word followed by N index
// words, then hands it to the network over a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for the count word
// COLLECT | accepting index words, remain_q still to come
// PRESENT | fire vector offered to the network, src stalled
module network_source #(
  parameter int NUM_INP   = 8,
  parameter int SRC_WIDTH = $clog2(NUM_INP + 1)
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [SRC_WIDTH-1:0] src,
  input  logic                 net_ready,
  output logic                 net_valid,
  output logic [NUM_INP-1:0]   net_inp,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_e;

  localparam logic [SRC_WIDTH-1:0] NUM_INP_W = SRC_WIDTH'(NUM_INP);
  localparam logic [SRC_WIDTH-1:0] ONE_W     = SRC_WIDTH'(1);

  state_e               state_q;
  logic [SRC_WIDTH-1:0] remain_q;
  logic [NUM_INP-1:0]   net_inp_q;
  logic                 err_q;
  logic [NUM_INP-1:0]   idx_oh_d;
  logic                 src_xfer;
  logic                 net_xfer;

  assign src_ready = (state_q == IDLE) || (state_q == COLLECT);
  assign net_valid = (state_q == PRESENT);
  assign net_inp   = net_inp_q;
  assign err       = err_q;
  assign src_xfer  = src_valid && src_ready;
  assign net_xfer  = net_valid && net_ready;

  // Out-of-range indices decode to all-zero, so they never set a bit.
  always_comb begin
    idx_oh_d = '0;
    for (int i = 0; i < NUM_INP; i++) begin
      if (src == SRC_WIDTH'(i)) idx_oh_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q   <= IDLE;
      remain_q  <= '0;
      net_inp_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (src_xfer) begin
            if (src <= NUM_INP_W) begin
              remain_q  <= src;
              net_inp_q <= '0;
              state_q   <= (src == '0) ? PRESENT : COLLECT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (src_xfer) begin
            if (src < NUM_INP_W) net_inp_q <= net_inp_q | idx_oh_d;
            else                 err_q     <= 1'b1;
            // A bad index still consumes one slot of the announced count.
            remain_q <= remain_q - ONE_W;
            if (remain_q == ONE_W) state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (net_xfer) begin
            state_q   <= IDLE;
            net_inp_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
